// File: rtl/inst_loader.sv
// AXI4-Lite staging port for 96-bit accelerator instructions: three staged words are committed
// into the fetch stage's instruction memory write port, with load status readable by the host.
module inst_loader #(
  parameter int CMD_WIDTH      = 3,
  parameter int CMD_END        = 7,
  parameter int AXI_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [95:0]               inst_out,
  output logic [31:0]               inst_addr_out,
  output logic                      inst_wr_en_out,
  input  logic [3:0]                fetch_state_in,
  output logic [1:0]                o_dbg_wr_state,
  output logic [1:0]                o_dbg_rd_state
);

  // Handshake rule: a beat transfers on a rising edge where valid and ready are both high;
  // the master holds address/data stable from valid until that edge, and ready never waits on
  // anything but our own FSM state.

  localparam logic [2:0]  OFF_W0      = 3'd0;
  localparam logic [2:0]  OFF_W1      = 3'd1;
  localparam logic [2:0]  OFF_W2      = 3'd2;
  localparam logic [2:0]  OFF_COMMIT  = 3'd3;
  localparam logic [2:0]  OFF_STATUS  = 3'd4;
  localparam logic [2:0]  OFF_CTRL    = 3'd5;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [10:0] COUNT_MAX   = 11'h7FF;
  localparam logic [CMD_WIDTH-1:0] CMD_END_CODE = CMD_WIDTH'(CMD_END);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  wr_state_t   r_wr_state, w_wr_next;
  rd_state_t   r_rd_state, w_rd_next;
  logic        w_awready, w_bvalid, w_arready, w_rvalid;

  logic [31:0] r_w0, r_w1, r_w2;
  logic [95:0] r_inst;
  logic [31:0] r_inst_addr;
  logic        r_inst_wr_en;
  logic        r_end_loaded;
  logic [10:0] r_inst_count;
  logic [1:0]  r_bresp;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic        w_wr_fire, w_rd_fire;
  logic [2:0]  w_wr_off, w_rd_off;
  logic        w_commit, w_ctrl_clear;
  logic [31:0] w_status;
  logic        w_unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------- write channel FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    w_awready = 1'b0;
    w_bvalid  = 1'b0;
    case (r_wr_state)
      W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_wr_next = W_ACK;
      W_ACK: begin
        w_awready = 1'b1;
        w_wr_next = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi_bready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  // ---------------- read channel FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_rd_state)
      R_IDLE: if (s_axi_arvalid) w_rd_next = R_ACK;
      R_ACK: begin
        w_arready = 1'b1;
        w_rd_next = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (s_axi_rready) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // ---------------- write decode ----------------
  assign w_wr_fire    = (r_wr_state == W_ACK);
  assign w_wr_off     = s_axi_awaddr[4:2];
  assign w_commit     = w_wr_fire && (w_wr_off == OFF_COMMIT) && (s_axi_wstrb != 4'b0000);
  assign w_ctrl_clear = w_wr_fire && (w_wr_off == OFF_CTRL) && s_axi_wstrb[0] && s_axi_wdata[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w0 <= '0;
      r_w1 <= '0;
      r_w2 <= '0;
    end else if (w_wr_fire) begin
      case (w_wr_off)
        OFF_W0:  r_w0 <= merge_bytes(r_w0, s_axi_wdata, s_axi_wstrb);
        OFF_W1:  r_w1 <= merge_bytes(r_w1, s_axi_wdata, s_axi_wstrb);
        OFF_W2:  r_w2 <= merge_bytes(r_w2, s_axi_wdata, s_axi_wstrb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bresp <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_bresp <= (w_wr_off <= OFF_CTRL) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Commit strobe lands in the cycle after the handshake, together with bvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_wr_en <= 1'b0;
      r_inst       <= '0;
      r_inst_addr  <= '0;
    end else begin
      r_inst_wr_en <= w_commit;
      if (w_commit) begin
        r_inst      <= {r_w2, r_w1, r_w0};
        r_inst_addr <= s_axi_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_end_loaded <= 1'b0;
      r_inst_count <= '0;
    end else if (w_ctrl_clear) begin
      r_end_loaded <= 1'b0;
      r_inst_count <= '0;
    end else if (w_commit) begin
      if (r_inst_count != COUNT_MAX) r_inst_count <= r_inst_count + 11'd1;
      if (r_w0[CMD_WIDTH-1:0] == CMD_END_CODE) r_end_loaded <= 1'b1;
    end
  end

  // ---------------- read decode ----------------
  assign w_rd_fire = (r_rd_state == R_ACK);
  assign w_rd_off  = s_axi_araddr[4:2];
  assign w_status  = {12'd0, fetch_state_in, 4'd0, r_inst_count, r_end_loaded};

  // Sampled from pre-update registers, so a same-cycle commit is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_rd_fire) begin
      r_rresp <= RESP_OKAY;
      case (w_rd_off)
        OFF_W0:     r_rdata <= r_w0;
        OFF_W1:     r_rdata <= r_w1;
        OFF_W2:     r_rdata <= r_w2;
        OFF_COMMIT: r_rdata <= '0;
        OFF_STATUS: r_rdata <= w_status;
        OFF_CTRL:   r_rdata <= '0;
        default: begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      endcase
    end
  end

  assign w_unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                                s_axi_araddr[AXI_ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

  assign s_axi_awready  = w_awready;
  assign s_axi_wready   = w_awready;
  assign s_axi_bvalid   = w_bvalid;
  assign s_axi_bresp    = r_bresp;
  assign s_axi_arready  = w_arready;
  assign s_axi_rvalid   = w_rvalid;
  assign s_axi_rdata    = r_rdata;
  assign s_axi_rresp    = r_rresp;
  assign inst_out       = r_inst;
  assign inst_addr_out  = r_inst_addr;
  assign inst_wr_en_out = r_inst_wr_en;
  assign o_dbg_wr_state = r_wr_state;
  assign o_dbg_rd_state = r_rd_state;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed register-map scenarios plus random AXI traffic scored against
// a register-level model of staging words, commit queue and load status.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [95:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_wr_en_out;
  logic [3:0]  fetch_state_in;
  logic [1:0]  dbg_wr_state;
  logic [1:0]  dbg_rd_state;

  inst_loader #(.CMD_WIDTH(3), .CMD_END(7), .AXI_ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .inst_out(inst_out), .inst_addr_out(inst_addr_out), .inst_wr_en_out(inst_wr_en_out),
    .fetch_state_in(fetch_state_in),
    .o_dbg_wr_state(dbg_wr_state), .o_dbg_rd_state(dbg_rd_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [127:0]  exp_q[$];
  logic [31:0]   m_w[3];
  int            m_count;
  bit            m_end;
  bit            prev_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_w[i] = 32'd0;
    m_count = 0;
    m_end   = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit commits);
    int off;
    off     = int'(addr[4:2]);
    resp    = (off <= 5) ? 2'b00 : 2'b10;
    commits = 1'b0;
    if (off < 3) begin
      m_w[off] = lane_merge(m_w[off], data, strb);
    end else if (off == 3 && strb != 4'd0) begin
      exp_q.push_back({data, m_w[2], m_w[1], m_w[0]});
      if (m_count < 2047) m_count++;
      if (m_w[0] % 8 == 7) m_end = 1'b1;
      commits = 1'b1;
    end else if (off == 5 && strb[0] && data[0]) begin
      m_count = 0;
      m_end   = 1'b0;
    end
  endtask

  task automatic model_read(input logic [7:0] addr, input logic [3:0] fetch,
                            output logic [31:0] data, output logic [1:0] resp);
    int off;
    off  = int'(addr[4:2]);
    resp = (off <= 5) ? 2'b00 : 2'b10;
    data = 32'd0;
    if (off < 3) data = m_w[off];
    else if (off == 4) data = (32'(fetch) << 16) + (32'(m_count) * 2) + 32'(m_end);
  endtask

  // ---------------- commit monitor ----------------
  always @(negedge clk) begin
    if (inst_wr_en_out === 1'b1) begin
      chk("strobe_one_cycle", prev_en, 0);
      if (exp_q.size() == 0) chk("commit_expected", inst_wr_en_out, 0);
      else chk("commit_payload", {inst_addr_out, inst_out}, exp_q.pop_front());
    end
    prev_en = (inst_wr_en_out === 1'b1);
  end

  // ---------------- driver tasks (start and end 1 time unit after a rising edge) ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    logic [1:0] exp_resp;
    bit exp_commit;
    model_write(addr, data, strb, exp_resp, exp_commit);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_axi_awready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("aw_latency", n, 1);
    chk("wready_with_awready", s_axi_wready, 1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (s_axi_bvalid !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("b_latency", n, 0);
    chk("bresp", s_axi_bresp, exp_resp);
    chk("strobe_with_bvalid", inst_wr_en_out, exp_commit);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_axi_arready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("ar_latency", n, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (s_axi_rvalid !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("r_latency", n, 0);
    data = s_axi_rdata; resp = s_axi_rresp;
    @(posedge clk); #1;
  endtask

  task automatic check_read(input logic [7:0] addr);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    model_read(addr, fetch_state_in, ed, er);
    axi_read(addr, d, r);
    chk("rdata_model", d, ed);
    chk("rresp_model", r, er);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    logic [7:0]  a;
    bit          dummy_c;
    int          n, cnt, op;

    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1; fetch_state_in = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    @(negedge clk);
    chk("reset_handshake", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                            s_axi_rvalid, s_axi_bresp, s_axi_rresp}, 0);
    chk("reset_rdata", s_axi_rdata, 0);
    chk("reset_inst", {inst_wr_en_out, inst_addr_out, inst_out}, 0);
    @(posedge clk); #1;

    fetch_state_in = 4'h3;
    axi_read(8'h10, d, r);
    chk("status_after_reset", d, 32'h0003_0000);
    chk("status_rresp", r, 2'b00);
    fetch_state_in = 4'h0;

    // basic staging and commit
    axi_write(8'h00, 32'h1111_1110, 4'hF);
    axi_write(8'h04, 32'h2222_2222, 4'hF);
    axi_write(8'h08, 32'h3333_3333, 4'hF);
    axi_write(8'h0C, 32'h0000_0005, 4'hF);
    repeat (3) @(posedge clk); #1;
    chk("inst_hold", {inst_addr_out, inst_out}, {32'h5, 96'h33333333_22222222_11111110});
    chk("strobe_low_after", inst_wr_en_out, 0);
    axi_read(8'h10, d, r);
    chk("status_count1", d, 32'h0000_0002);

    // end-of-program command, then clear
    axi_write(8'h00, 32'h0000_0007, 4'hF);
    axi_write(8'h0C, 32'h0000_0006, 4'hF);
    axi_read(8'h10, d, r);
    chk("status_end_count2", d, 32'h0000_0005);
    axi_write(8'h14, 32'h0000_0001, 4'hF);
    axi_read(8'h10, d, r);
    chk("status_cleared", d, 32'h0000_0000);
    axi_read(8'h0C, d, r);
    chk("commit_reads_zero", d, 0);

    // byte lanes and empty-strobe commit
    axi_write(8'h04, 32'hAABB_CCDD, 4'b0010);
    axi_read(8'h04, d, r);
    chk("w1_byte_lane", d, 32'h2222_CC22);
    axi_write(8'h0C, 32'h0000_0009, 4'b0000);

    // bvalid held with bready low; second write blocked
    s_axi_bready = 1'b0;
    model_write(8'h00, 32'hCAFE_0001, 4'hF, er, dummy_c);
    s_axi_awaddr = 8'h00; s_axi_wdata = 32'hCAFE_0001; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_axi_awready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("hold_aw_latency", n, 1);
    @(posedge clk); #1;
    model_write(8'h08, 32'hBEEF_0002, 4'hF, er, dummy_c);
    s_axi_awaddr = 8'h08; s_axi_wdata = 32'hBEEF_0002;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (s_axi_bvalid === 1'b1 && s_axi_awready === 1'b0) cnt++;
    end
    chk("bvalid_held_aw_blocked", cnt, 5);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    n = 0;
    @(negedge clk);
    while (s_axi_awready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("second_aw_latency", n, 1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (s_axi_bvalid !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("second_b_latency", n, 0);
    @(posedge clk); #1;
    check_read(8'h00);
    check_read(8'h08);

    // unmapped offset
    axi_write(8'h1C, 32'h1234_5678, 4'hF);
    axi_read(8'h1C, d, r);
    chk("unmapped_rdata", d, 0);
    chk("unmapped_rresp", r, 2'b10);

    // STATUS read in the same cycle as a commit sees the old value
    fetch_state_in = 4'hA;
    model_read(8'h10, fetch_state_in, ed, er);
    fork
      axi_write(8'h0C, 32'h0000_0040, 4'hF);
      axi_read(8'h10, d, r);
    join
    chk("status_pre_update", d, ed);
    check_read(8'h10);

    // reset during the commit handshake cycle
    s_axi_awaddr = 8'h0C; s_axi_wdata = 32'h0000_0009; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_axi_awready !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("rst_ack_reached", n, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_axi_bvalid !== 1'b0 || inst_wr_en_out !== 1'b0) cnt++;
    end
    chk("no_b_or_strobe_after_reset", cnt, 0);
    @(posedge clk); #1;
    fetch_state_in = 4'h0;
    axi_read(8'h10, d, r);
    chk("status_after_mid_reset", d, 0);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        d = $urandom();
        if ($urandom_range(0, 2) == 0) d[2:0] = 3'd7;
        axi_write(8'($urandom_range(0, 2) * 4), d, 4'($urandom_range(0, 15)));
      end else if (op <= 5) begin
        axi_write(8'h0C, $urandom(), ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      end else if (op == 6) begin
        axi_write(8'h14, ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0, 4'hF);
      end else if (op <= 8) begin
        fetch_state_in = 4'($urandom_range(0, 15));
        check_read(8'($urandom_range(0, 7) * 4));
      end else begin
        a = 8'($urandom_range(0, 255));
        if (a[4:2] == 3'd3 || a[4:2] == 3'd5) check_read(a);
        else axi_write(a, $urandom(), 4'hF);
      end
    end

    // counter saturation
    axi_write(8'h14, 32'h1, 4'hF);
    axi_write(8'h00, 32'h0000_0000, 4'hF);
    for (int i = 0; i < 2050; i++) axi_write(8'h0C, 32'(i), 4'hF);
    fetch_state_in = 4'h0;
    axi_read(8'h10, d, r);
    chk("count_saturated", d, 32'h0000_0FFE);

    repeat (2) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
